// File: rtl/pipe_stage_reg_if.sv
// Bundle for one inter-stage pipeline register: upstream slot, control (stall/flush),
// registered downstream slot and performance counters.
// in_valid/out_valid mark a real instruction. There is no ready; stall/flush are the only back-pressure.
interface pipe_stage_reg_if #(
  parameter int PAYLOAD_W = 32,
  parameter int TNEW_W    = 2,
  parameter int CNT_W     = 16
);
  logic                 stall;
  logic                 flush;
  logic                 in_valid;
  logic [31:0]          in_pc;
  logic [PAYLOAD_W-1:0] in_payload;
  logic [4:0]           in_dst;
  logic                 in_regwrite;
  logic                 in_memwrite;
  logic [TNEW_W-1:0]    in_tnew;
  logic                 out_valid;
  logic [31:0]          out_pc;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [4:0]           out_dst;
  logic                 out_regwrite;
  logic                 out_memwrite;
  logic [TNEW_W-1:0]    out_tnew;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     bubble_cnt;

  modport master (
    output stall, flush, in_valid, in_pc, in_payload, in_dst, in_regwrite, in_memwrite, in_tnew,
    input  out_valid, out_pc, out_payload, out_dst, out_regwrite, out_memwrite, out_tnew,
           stall_cnt, bubble_cnt
  );

  modport slave (
    input  stall, flush, in_valid, in_pc, in_payload, in_dst, in_regwrite, in_memwrite, in_tnew,
    output out_valid, out_pc, out_payload, out_dst, out_regwrite, out_memwrite, out_tnew,
           stall_cnt, bubble_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic MIPS inter-stage pipeline register with hold/bubble control, valid bit,
// Tnew countdown and saturating hold/bubble performance counters.
module pipe_stage_reg #(
  parameter int          PAYLOAD_W = 32,
  parameter int          TNEW_W    = 2,
  parameter logic [31:0] PC_RESET  = 32'h3000,
  parameter int          CNT_W     = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_reg_if.slave  bus
);

  logic                 valid_q,      valid_d;
  logic [31:0]          pc_q,         pc_d;
  logic [PAYLOAD_W-1:0] payload_q,    payload_d;
  logic [4:0]           dst_q,        dst_d;
  logic                 regwrite_q,   regwrite_d;
  logic                 memwrite_q,   memwrite_d;
  logic [TNEW_W-1:0]    tnew_q,       tnew_d;
  logic [CNT_W-1:0]     stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;

  // Priority: flush > stall > load (reset handled in the register process).
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    payload_d    = payload_q;
    dst_d        = dst_q;
    regwrite_d   = regwrite_q;
    memwrite_d   = memwrite_q;
    tnew_d       = tnew_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (bus.flush) begin
      // Bubble keeps the squashed slot's PC for debug.
      valid_d    = 1'b0;
      pc_d       = bus.in_pc;
      payload_d  = '0;
      dst_d      = '0;
      regwrite_d = 1'b0;
      memwrite_d = 1'b0;
      tnew_d     = '0;
      if (bubble_cnt_q != {CNT_W{1'b1}}) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else if (bus.stall) begin
      if (stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      valid_d    = bus.in_valid;
      pc_d       = bus.in_pc;
      payload_d  = bus.in_payload;
      dst_d      = bus.in_dst;
      // Writes to $0 are architecturally void, so never advertise them to forwarding.
      regwrite_d = bus.in_valid & bus.in_regwrite & (bus.in_dst != 5'd0);
      memwrite_d = bus.in_valid & bus.in_memwrite;
      tnew_d     = (bus.in_valid && bus.in_tnew != '0) ? bus.in_tnew - TNEW_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      pc_q         <= PC_RESET;
      payload_q    <= '0;
      dst_q        <= '0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      tnew_q       <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      payload_q    <= payload_d;
      dst_q        <= dst_d;
      regwrite_q   <= regwrite_d;
      memwrite_q   <= memwrite_d;
      tnew_q       <= tnew_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_payload  = payload_q;
  assign bus.out_dst      = dst_q;
  assign bus.out_regwrite = regwrite_q;
  assign bus.out_memwrite = memwrite_q;
  assign bus.out_tnew     = tnew_q;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.bubble_cnt   = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default-width instance plus a CNT_W=2 instance
// for counter saturation.
module tb_pipe_stage_reg;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pipe_stage_reg_if #(.PAYLOAD_W(32), .TNEW_W(2), .CNT_W(16)) bus ();
  pipe_stage_reg_if #(.PAYLOAD_W(32), .TNEW_W(2), .CNT_W(2))  bus2 ();

  pipe_stage_reg #(.PAYLOAD_W(32), .TNEW_W(2), .PC_RESET(32'h3000), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  pipe_stage_reg #(.PAYLOAD_W(32), .TNEW_W(2), .PC_RESET(32'h3000), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] pl,
                       input logic [4:0] dst, input logic rw, input logic mw,
                       input logic [1:0] tn);
    bus.in_valid    = v;
    bus.in_pc       = pc;
    bus.in_payload  = pl;
    bus.in_dst      = dst;
    bus.in_regwrite = rw;
    bus.in_memwrite = mw;
    bus.in_tnew     = tn;
  endtask

  task automatic test_reset();
    bus.stall = 1'b1; bus.flush = 1'b1;
    bus2.stall = 1'b1; bus2.flush = 1'b1;
    drive(1'b1, 32'h1234_5678, 32'hffff_ffff, 5'd7, 1'b1, 1'b1, 2'd3);
    reset = 1'b1;
    step();
    checks++; if (bus.out_pc !== 32'h3000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", bus.out_pc, 32'h3000); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_tnew !== 2'd0) begin failures++; $display("FAIL reset_tnew got=%0d exp=0", bus.out_tnew); end
    checks++; if (bus.out_payload !== 32'd0 || bus.out_dst !== 5'd0) begin failures++; $display("FAIL reset_payload got=%h/%0d exp=0/0", bus.out_payload, bus.out_dst); end
    checks++; if (bus.out_regwrite !== 1'b0 || bus.out_memwrite !== 1'b0) begin failures++; $display("FAIL reset_we got=%b%b exp=00", bus.out_regwrite, bus.out_memwrite); end
    checks++; if (bus.stall_cnt !== 16'd0 || bus.bubble_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.stall_cnt, bus.bubble_cnt); end
    reset = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus2.stall = 1'b0; bus2.flush = 1'b0;
  endtask

  task automatic test_load();
    drive(1'b1, 32'h3004, 32'hdead_beef, 5'd8, 1'b1, 1'b0, 2'd2);
    step();
    checks++; if (bus.out_pc !== 32'h3004) begin failures++; $display("FAIL load_pc got=%h exp=%h", bus.out_pc, 32'h3004); end
    checks++; if (bus.out_regwrite !== 1'b1) begin failures++; $display("FAIL load_regwrite got=%b exp=1", bus.out_regwrite); end
    checks++; if (bus.out_tnew !== 2'd1) begin failures++; $display("FAIL load_tnew2 got=%0d exp=1", bus.out_tnew); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_payload !== 32'hdead_beef || bus.out_dst !== 5'd8) begin
      failures++; $display("FAIL load_fields got=%b/%h/%0d exp=1/deadbeef/8", bus.out_valid, bus.out_payload, bus.out_dst); end
    drive(1'b1, 32'h3004, 32'h0000_0011, 5'd8, 1'b1, 1'b1, 2'd0);
    step();
    checks++; if (bus.out_tnew !== 2'd0) begin failures++; $display("FAIL load_tnew0 got=%0d exp=0", bus.out_tnew); end
    checks++; if (bus.out_memwrite !== 1'b1) begin failures++; $display("FAIL load_memwrite got=%b exp=1", bus.out_memwrite); end
    drive(1'b1, 32'h3008, 32'h0000_0022, 5'd9, 1'b0, 1'b0, 2'd1);
    step();
    checks++; if (bus.out_tnew !== 2'd0 || bus.out_regwrite !== 1'b0 || bus.out_memwrite !== 1'b0) begin
      failures++; $display("FAIL load_tnew1 got=%0d/%b/%b exp=0/0/0", bus.out_tnew, bus.out_regwrite, bus.out_memwrite); end
  endtask

  task automatic test_zero_dst();
    drive(1'b1, 32'h3010, 32'h0000_0033, 5'd0, 1'b1, 1'b0, 2'd3);
    step();
    checks++; if (bus.out_regwrite !== 1'b0) begin failures++; $display("FAIL zero_dst_regwrite got=%b exp=0", bus.out_regwrite); end
    checks++; if (bus.out_tnew !== 2'd2 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL zero_dst_tnew got=%0d/%b exp=2/1", bus.out_tnew, bus.out_valid); end
  endtask

  task automatic test_invalid_load();
    drive(1'b0, 32'h3014, 32'hcafe_f00d, 5'd5, 1'b1, 1'b1, 2'd3);
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_regwrite !== 1'b0 || bus.out_memwrite !== 1'b0 || bus.out_tnew !== 2'd0) begin
      failures++; $display("FAIL invalid_ctrl got=%b/%b/%b/%0d exp=0/0/0/0", bus.out_valid, bus.out_regwrite, bus.out_memwrite, bus.out_tnew); end
    checks++; if (bus.out_pc !== 32'h3014 || bus.out_payload !== 32'hcafe_f00d || bus.out_dst !== 5'd5) begin
      failures++; $display("FAIL invalid_data got=%h/%h/%0d exp=3014/cafef00d/5", bus.out_pc, bus.out_payload, bus.out_dst); end
    checks++; if (bus.bubble_cnt !== 16'd0) begin failures++; $display("FAIL invalid_bubble_cnt got=%0d exp=0", bus.bubble_cnt); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h3008, 32'h1111_2222, 5'd3, 1'b1, 1'b0, 2'd3);
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h4000 + 32'(i * 4), 32'(i), 5'(i + 10), 1'b0, 1'b1, 2'd1);
      step();
    end
    bus.stall = 1'b0;
    checks++; if (bus.out_pc !== 32'h3008 || bus.out_payload !== 32'h1111_2222 || bus.out_dst !== 5'd3) begin
      failures++; $display("FAIL stall_data got=%h/%h/%0d exp=3008/11112222/3", bus.out_pc, bus.out_payload, bus.out_dst); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_regwrite !== 1'b1 || bus.out_memwrite !== 1'b0 || bus.out_tnew !== 2'd2) begin
      failures++; $display("FAIL stall_ctrl got=%b/%b/%b/%0d exp=1/1/0/2", bus.out_valid, bus.out_regwrite, bus.out_memwrite, bus.out_tnew); end
    checks++; if (bus.stall_cnt !== 16'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", bus.stall_cnt); end
  endtask

  task automatic test_flush_beats_stall();
    bus.stall = 1'b1; bus.flush = 1'b1;
    drive(1'b1, 32'h300c, 32'h5555_aaaa, 5'd4, 1'b1, 1'b1, 2'd2);
    step();
    bus.stall = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_memwrite !== 1'b0 || bus.out_regwrite !== 1'b0) begin
      failures++; $display("FAIL flush_ctrl got=%b/%b/%b exp=0/0/0", bus.out_valid, bus.out_memwrite, bus.out_regwrite); end
    checks++; if (bus.out_pc !== 32'h300c) begin failures++; $display("FAIL flush_pc got=%h exp=300c", bus.out_pc); end
    checks++; if (bus.out_payload !== 32'd0 || bus.out_dst !== 5'd0 || bus.out_tnew !== 2'd0) begin
      failures++; $display("FAIL flush_fields got=%h/%0d/%0d exp=0/0/0", bus.out_payload, bus.out_dst, bus.out_tnew); end
    checks++; if (bus.bubble_cnt !== 16'd1 || bus.stall_cnt !== 16'd3) begin
      failures++; $display("FAIL flush_cnt got=%0d/%0d exp=1/3", bus.bubble_cnt, bus.stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    bus.stall = 1'b1;
    reset = 1'b1;
    drive(1'b1, 32'h3020, 32'h7777_7777, 5'd6, 1'b1, 1'b1, 2'd3);
    step();
    reset = 1'b0;
    bus.stall = 1'b0;
    checks++; if (bus.out_pc !== 32'h3000 || bus.out_valid !== 1'b0 || bus.stall_cnt !== 16'd0 || bus.bubble_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_mid_stall got=%h/%b/%0d/%0d exp=3000/0/0/0", bus.out_pc, bus.out_valid, bus.stall_cnt, bus.bubble_cnt); end
    step();
    checks++; if (bus.out_pc !== 32'h3020 || bus.out_valid !== 1'b1 || bus.out_tnew !== 2'd2 || bus.out_memwrite !== 1'b1) begin
      failures++; $display("FAIL after_reset_load got=%h/%b/%0d/%b exp=3020/1/2/1", bus.out_pc, bus.out_valid, bus.out_tnew, bus.out_memwrite); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    bus2.stall = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      exp_cnt = (i >= 3) ? 2'd3 : 2'(i);
      checks++; if (bus2.stall_cnt !== exp_cnt) begin failures++; $display("FAIL sat_stall_cnt edge=%0d got=%0d exp=%0d", i, bus2.stall_cnt, exp_cnt); end
    end
    bus2.stall = 1'b0;
    bus2.flush = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      exp_cnt = (i >= 3) ? 2'd3 : 2'(i);
      checks++; if (bus2.bubble_cnt !== exp_cnt) begin failures++; $display("FAIL sat_bubble_cnt edge=%0d got=%0d exp=%0d", i, bus2.bubble_cnt, exp_cnt); end
    end
    bus2.flush = 1'b0;
    checks++; if (bus2.stall_cnt !== 2'd3) begin failures++; $display("FAIL sat_stall_hold got=%0d exp=3", bus2.stall_cnt); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'd0);
    bus2.stall = 1'b0; bus2.flush = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_pc = 32'h0; bus2.in_payload = 32'h0;
    bus2.in_dst = 5'd0; bus2.in_regwrite = 1'b0; bus2.in_memwrite = 1'b0; bus2.in_tnew = 2'd0;
    #2;
    test_reset();
    test_load();
    test_zero_dst();
    test_invalid_load();
    test_stall();
    test_flush_beats_stall();
    test_reset_mid_stall();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
